// File: rtl/mac_vector_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mac_vector_sequencer                                            |
// | Purpose  : Upstream control stage for the 27x18 overlay MAC. Accepts a     |
// |            valid/ready stream of operand pairs grouped into vectors by a   |
// |            last flag, issues one pair per cycle to the overlay, steers the |
// |            overlay X input so each vector accumulates into one 48-bit dot  |
// |            product, and presents that sum on a valid/ready result port.    |
// | Ports    : clk, reset (async, active-low)                                  |
// |            in_valid/in_ready/in_a/in_b/in_last   operand pair stream       |
// |            ovl_a/ovl_b/ovl_mode/ovl_cin/ovl_x    drive to the overlay      |
// |            ovl_s/ovl_cout                        overlay S_reg/COUT_reg    |
// |            out_valid/out_ready/out_data/out_cout/out_count/out_trunc       |
// |                                                  result stream             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mac_vector_sequencer #(
  parameter logic [1:0] MODE_ACC = 2'b00,
  parameter int         MAX_LEN  = 1024,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [26:0]      in_a,
  input  logic [17:0]      in_b,
  input  logic             in_last,
  output logic [26:0]      ovl_a,
  output logic [17:0]      ovl_b,
  output logic [1:0]       ovl_mode,
  output logic             ovl_cin,
  output logic [47:0]      ovl_x,
  input  logic [47:0]      ovl_s,
  input  logic             ovl_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [47:0]      out_data,
  output logic             out_cout,
  output logic [CNT_W-1:0] out_count,
  output logic             out_trunc
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // Count value seen while accepting the MAX_LEN-th pair of a vector.
  localparam logic [CNT_W-1:0] C_LAST_IDX   = CNT_W'(MAX_LEN - 1);
  // The final S_reg is captured on the fourth edge after the last accept:
  // two edges for the overlay product/ALU pipeline, plus margin so the
  // capture never races the last ALU update.
  localparam logic [1:0]       C_DRAIN_LAST = 2'd3;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_set_trunc;
  logic             w_capture;
  logic             w_release;

  logic [26:0]      r_ovl_a;
  logic [17:0]      r_ovl_b;
  logic             r_first;
  logic             r_first_d1;
  logic [CNT_W-1:0] r_count;
  logic             r_trunc;
  logic [1:0]       r_drain_cnt;
  logic             r_out_valid;
  logic [47:0]      r_out_data;
  logic             r_out_cout;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_trunc;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and handshake decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_set_trunc = 1'b0;
    in_ready    = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = in_last ? ST_DRAIN : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        in_ready = 1'b1;
        // Bubbles keep the vector open indefinitely; only an accept ends it.
        if (in_valid && (in_last || (r_count == C_LAST_IDX))) begin
          w_state_nxt = ST_DRAIN;
          w_set_trunc = ~in_last;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == C_DRAIN_LAST) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          w_release   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_accept = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // Issue, vector bookkeeping and result capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovl_a     <= '0;
      r_ovl_b     <= '0;
      r_first     <= 1'b0;
      r_first_d1  <= 1'b0;
      r_count     <= '0;
      r_trunc     <= 1'b0;
      r_drain_cnt <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_cout  <= 1'b0;
      r_out_count <= '0;
      r_out_trunc <= 1'b0;
    end else begin
      // A non-accept cycle issues 0*0 so the running sum is unaffected.
      r_ovl_a    <= w_accept ? in_a : '0;
      r_ovl_b    <= w_accept ? in_b : '0;
      r_first    <= w_accept & (r_state == ST_IDLE);
      r_first_d1 <= r_first;

      if (w_release) begin
        r_count <= '0;
        r_trunc <= 1'b0;
      end else begin
        if (w_accept) begin
          r_count <= r_count + CNT_W'(1);
        end
        if (w_set_trunc) begin
          r_trunc <= 1'b1;
        end
      end

      r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;

      if (w_capture) begin
        r_out_valid <= 1'b1;
        r_out_data  <= ovl_s;
        r_out_cout  <= ovl_cout;
        r_out_count <= r_count;
        r_out_trunc <= r_trunc;
      end else if (w_release) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Overlay drive. X is zeroed while the first product of a vector is in the
  // overlay's product registers, which also discards any stale S_reg from a
  // previous or aborted vector.
  // ---------------------------------------------------------------------------
  assign ovl_a     = r_ovl_a;
  assign ovl_b     = r_ovl_b;
  assign ovl_mode  = MODE_ACC;
  assign ovl_cin   = 1'b0;
  assign ovl_x     = r_first_d1 ? 48'd0 : ovl_s;

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_cout  = r_out_cout;
  assign out_count = r_out_count;
  assign out_trunc = r_out_trunc;

endmodule
`default_nettype wire

// File: tb/tb_mac_vector_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mac_vector_sequencer                                         |
// | Purpose  : Self-checking bench for mac_vector_sequencer with a behavioural |
// |            27x18 overlay model, a table of directed vectors, hand-written  |
// |            corner sequences and randomized vector streams.                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mac_vector_sequencer;

  localparam int MAX_LEN = 4;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [26:0]      in_a = '0;
  logic [17:0]      in_b = '0;
  logic             in_last = 1'b0;
  logic [26:0]      ovl_a;
  logic [17:0]      ovl_b;
  logic [1:0]       ovl_mode;
  logic             ovl_cin;
  logic [47:0]      ovl_x;
  logic [47:0]      ovl_s;
  logic             ovl_cout;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [47:0]      out_data;
  logic             out_cout;
  logic [CNT_W-1:0] out_count;
  logic             out_trunc;

  mac_vector_sequencer #(
    .MODE_ACC (2'b00),
    .MAX_LEN  (MAX_LEN),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .ovl_a     (ovl_a),
    .ovl_b     (ovl_b),
    .ovl_mode  (ovl_mode),
    .ovl_cin   (ovl_cin),
    .ovl_x     (ovl_x),
    .ovl_s     (ovl_s),
    .ovl_cout  (ovl_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cout  (out_cout),
    .out_count (out_count),
    .out_trunc (out_trunc)
  );

  always #5 clk = ~clk;

  // Overlay model: registered product, then S = P + X + CIN with carry out.
  // Held in reset together with the sequencer.
  logic signed [47:0] ovl_prod_w;
  logic signed [47:0] m_prod;
  logic [47:0]        m_s;
  logic               m_cout;
  assign ovl_prod_w = $signed(ovl_a) * $signed(ovl_b);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_prod <= '0;
      m_s    <= '0;
      m_cout <= 1'b0;
    end else begin
      m_prod         <= ovl_prod_w;
      {m_cout, m_s}  <= {1'b0, m_prod} + {1'b0, ovl_x} + {48'd0, ovl_cin};
    end
  end
  assign ovl_s    = m_s;
  assign ovl_cout = m_cout;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [47:0] data;
    int          count;
    bit          trunc;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // 0: always ready, 1: random ready, 2: held not ready
  int rdy_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one pair until accepted; returns #1 after the accepting edge.
  task automatic send_pair(input logic [26:0] a, input logic [17:0] b, input bit last);
    int guard;
    bit acc;
    guard    = 0;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    do begin
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) check("send_timeout", 64'(acc), 64'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_a     = '0;
    in_b     = '0;
  endtask

  task automatic push_exp(input logic [47:0] d, input int c, input bit t);
    exp_t e;
    e.data  = d;
    e.count = c;
    e.trunc = t;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, 64'(out_valid), 64'd1);
  endtask

  // Reference model for streams: plain dot-product arithmetic, cut a vector
  // at the last flag or at MAX_LEN elements.
  longint m_sum = 0;
  int     m_cnt = 0;
  task automatic model_pair(input logic [26:0] a, input logic [17:0] b, input bit last);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    m_sum += sa * sb;
    m_cnt++;
    if (last || m_cnt == MAX_LEN) begin
      push_exp(m_sum[47:0], m_cnt, !last);
      m_sum = 0;
      m_cnt = 0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Ready generator (sole writer of out_ready)
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Result monitor: a handshake completes at the next posedge when both
  // out_valid and out_ready are high at the negedge.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (reset && out_valid) begin
      check("hold_in_ready", 64'(in_ready), 64'd0);
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_result: got data %0h count %0d, no result expected", out_data, out_count);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data",  64'(out_data),  64'(mon_e.data));
          check("out_count", 64'(out_count), 64'(mon_e.count));
          check("out_trunc", 64'(out_trunc), 64'(mon_e.trunc));
          // The bubble after the last pair leaves a carry-free P=0 add in COUT_reg.
          check("out_cout",  64'(out_cout),  64'd0);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    int               n;
    logic [3:0][26:0] a;
    logic [3:0][17:0] b;
    bit               last_final;
    int               gap1;
    logic [47:0]      exp_data;
    int               exp_count;
    bit               exp_trunc;
  } vec_t;
  vec_t tbl[7];

  initial begin
    tbl[0] = '{3, {27'd0, 27'h7FFFFFE, 27'd5, 27'd3}, {18'd0, 18'd7, 18'd6, 18'd4},
               1'b1, 0, 48'd28, 3, 1'b0};
    tbl[1] = '{3, {27'd0, 27'h7FFFFFE, 27'd5, 27'd3}, {18'd0, 18'd7, 18'd6, 18'd4},
               1'b1, 2, 48'd28, 3, 1'b0};
    tbl[2] = '{1, {27'd0, 27'd0, 27'd0, 27'd7}, {18'd0, 18'd0, 18'd0, 18'h3FFFF},
               1'b1, 0, 48'hFFFF_FFFF_FFF9, 1, 1'b0};
    tbl[3] = '{4, {27'd1, 27'd1, 27'd1, 27'd1}, {18'd1, 18'd1, 18'd1, 18'd1},
               1'b0, 0, 48'd4, 4, 1'b1};
    tbl[4] = '{2, {27'd0, 27'd0, 27'd1, 27'd1}, {18'd0, 18'd0, 18'd1, 18'd1},
               1'b1, 0, 48'd2, 2, 1'b0};
    tbl[5] = '{4, {27'h4000000, 27'h4000000, 27'h4000000, 27'h4000000},
               {18'h20000, 18'h20000, 18'h20000, 18'h20000},
               1'b1, 0, 48'h2000_0000_0000, 4, 1'b0};
    tbl[6] = '{1, {27'd0, 27'd0, 27'd0, 27'h3FFFFFF}, {18'd0, 18'd0, 18'd0, 18'h1FFFF},
               1'b1, 0, 48'h07FF_FBFE_0001, 1, 1'b0};

    // Reset release and idle state
    idle(3);
    reset = 1'b1;
    idle(10);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_ovl_a",     64'(ovl_a),     64'd0);
    check("rst_ovl_b",     64'(ovl_b),     64'd0);
    check("rst_ovl_mode",  64'(ovl_mode),  64'd0);
    check("rst_ovl_cin",   64'(ovl_cin),   64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    check("rst_out_trunc", 64'(out_trunc), 64'd0);

    // Table-driven vectors, consumer always ready
    rdy_mode = 0;
    for (int r = 0; r < 7; r++) begin
      push_exp(tbl[r].exp_data, tbl[r].exp_count, tbl[r].exp_trunc);
      for (int i = 0; i < tbl[r].n; i++) begin
        send_pair(tbl[r].a[i], tbl[r].b[i], tbl[r].last_final && (i == tbl[r].n - 1));
        if (i == 0) idle(tbl[r].gap1);
      end
    end
    wait_drain("table_drain");

    // Latency: out_valid rises exactly after the fourth edge past the last accept
    push_exp(48'd28, 3, 1'b0);
    send_pair(27'd3, 18'd4, 1'b0);
    send_pair(27'd5, 18'd6, 1'b0);
    send_pair(27'h7FFFFFE, 18'd7, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("latency_edge%0d", k), 64'(out_valid), (k == 4) ? 64'd1 : 64'd0);
    end
    wait_drain("latency_drain");

    // HOLD with consumer stalled for 5 cycles, then a second single vector
    rdy_mode = 2;
    push_exp(48'd20000, 1, 1'b0);
    send_pair(27'd100, 18'd200, 1'b1);
    wait_valid("hold_valid");
    for (int k = 0; k < 5; k++) begin
      check("hold_data",     64'(out_data),  64'd20000);
      check("hold_in_rdy0",  64'(in_ready),  64'd0);
      check("hold_valid_hi", 64'(out_valid), 64'd1);
      idle(1);
    end
    rdy_mode = 0;
    push_exp(48'hFFFF_FFFF_FFF9, 1, 1'b0);
    send_pair(27'd7, 18'h3FFFF, 1'b1);
    wait_drain("hold_drain");

    // Reset during DRAIN discards the vector
    send_pair(27'd10, 18'd10, 1'b1);
    idle(1);
    reset = 1'b0;
    #2;
    check("abort_drain_valid", 64'(out_valid), 64'd0);
    check("abort_drain_ready", 64'(in_ready),  64'd1);
    check("abort_drain_ovl_a", 64'(ovl_a),     64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    push_exp(48'd6, 1, 1'b0);
    send_pair(27'd2, 18'd3, 1'b1);
    wait_drain("abort_drain_next");

    // Reset during HOLD drops out_valid without a clock edge
    rdy_mode = 2;
    send_pair(27'd9, 18'd9, 1'b1);
    wait_valid("abort_hold_valid");
    #2;
    reset = 1'b0;
    #1;
    check("abort_hold_valid_lo", 64'(out_valid), 64'd0);
    check("abort_hold_data_clr", 64'(out_data),  64'd0);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    rdy_mode = 0;
    idle(2);

    // Randomized streams against the arithmetic reference model
    rdy_mode = 1;
    for (int v = 0; v < 40; v++) begin
      int len;
      len = int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++) begin
        logic [26:0] ra;
        logic [17:0] rb;
        bit          rl;
        ra = 27'($urandom);
        rb = 18'($urandom);
        rl = (i == len - 1);
        model_pair(ra, rb, rl);
        send_pair(ra, rb, rl);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      end
    end
    wait_drain("random_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
